// File: rtl/hex_display_pager.sv
// Captures one cipher block and pages it, NUM_DIGITS hex nibbles at a time, onto 7-seg digits.
// Optional build macro DISP_NEW_BLINK_EN: blink the display for one dwell period after a capture.
module hex_display_pager #(
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned BLINK_HALF   = 12_500_000,
    localparam int unsigned PAGE_BITS   = 4 * NUM_DIGITS,
    localparam int unsigned PAGES       = DATA_W / PAGE_BITS,
    localparam int unsigned PW          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    input  logic                    next_pulse,
    input  logic                    pause_tgl,
    output logic [7*NUM_DIGITS-1:0] segs,
    output logic [PW-1:0]           page_idx,
    output logic                    paused
);

    localparam int unsigned DW = $clog2(DWELL_CYCLES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHOW  = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    if ((DATA_W % PAGE_BITS) != 0 || DWELL_CYCLES < 2 || BLINK_HALF < 1) begin : g_param_err
        $error("hex_display_pager: illegal parameter combination");
    end

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [PW-1:0]     page_q, page_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic              capture, expire, step, blank_d;

    assign capture = in_valid & in_ready;
    assign expire  = (state_q == SHOW) && (dwell_q == DW'(DWELL_CYCLES - 1));
    assign step    = expire | (next_pulse & (state_q != IDLE));

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        page_d  = page_q;
        dwell_d = dwell_q;
        // Capture takes priority over any page advance in the same cycle.
        if (capture) begin
            buf_d   = in_data;
            page_d  = '0;
            dwell_d = '0;
        end else if (step) begin
            page_d  = (page_q == PW'(PAGES - 1)) ? '0 : page_q + PW'(1);
            dwell_d = '0;
        end else if (state_q == SHOW) begin
            dwell_d = dwell_q + DW'(1);
        end
        case (state_q)
            IDLE:    if (capture)   state_d = SHOW;
            SHOW:    if (pause_tgl) state_d = PAUSE;
            PAUSE:   if (pause_tgl) state_d = SHOW;
            default: state_d = IDLE;
        endcase
    end

`ifdef DISP_NEW_BLINK_EN
    localparam int unsigned HW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic          blink_q, blink_d, phase_q, phase_d;
    logic [DW-1:0] bcnt_q, bcnt_d;
    logic [HW-1:0] half_q, half_d;

    always_comb begin
        blink_d = blink_q;
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        half_d  = half_q;
        if (capture) begin
            blink_d = 1'b1;
            phase_d = 1'b0;
            bcnt_d  = '0;
            half_d  = '0;
        end else if (blink_q && state_q == SHOW) begin
            if (bcnt_q == DW'(DWELL_CYCLES - 1)) blink_d = 1'b0;
            bcnt_d = bcnt_q + DW'(1);
            if (half_q == HW'(BLINK_HALF - 1)) begin
                half_d  = '0;
                phase_d = ~phase_q;
            end else begin
                half_d = half_q + HW'(1);
            end
        end
        if ((next_pulse && state_q != IDLE && !capture) || state_d == PAUSE) blink_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
            phase_q <= 1'b0;
            bcnt_q  <= '0;
            half_q  <= '0;
        end else begin
            blink_q <= blink_d;
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
            half_q  <= half_d;
        end
    end

    assign blank_d = blink_d & phase_d;
`else
    assign blank_d = 1'b0;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Decode from next-state values so segs shows the new page on the cycle after it is chosen.
    logic [PAGE_BITS-1:0]    page_bits;
    logic [7*NUM_DIGITS-1:0] seg_dec, segs_d;

    assign page_bits = PAGE_BITS'(buf_d >> (32'(page_d) * PAGE_BITS));

    for (genvar k = 0; k < int'(NUM_DIGITS); k++) begin : g_dec
        assign seg_dec[7*k +: 7] = hex7(page_bits[4*k +: 4]);
    end

    assign segs_d = (state_d == IDLE || blank_d) ? '1 : seg_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            page_q   <= '0;
            dwell_q  <= '0;
            segs     <= '1;
            in_ready <= 1'b1;
            paused   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            page_q   <= page_d;
            dwell_q  <= dwell_d;
            segs     <= segs_d;
            in_ready <= (state_d != PAUSE);
            paused   <= (state_d == PAUSE);
        end
    end

    assign page_idx = page_q;

endmodule

// File: tb/tb_hex_display_pager.sv
// Directed bench for hex_display_pager with a scoreboard queue of expected outputs.
module tb_hex_display_pager;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned ND     = 8;
`ifdef DISP_NEW_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              next_pulse = 1'b0;
    logic              pause_tgl = 1'b0;
    logic [7*ND-1:0]   segs;
    logic [1:0]        page_idx;
    logic              paused;

    hex_display_pager #(
        .DATA_W(DATA_W),
        .NUM_DIGITS(ND),
        .DWELL_CYCLES(4),
        .BLINK_HALF(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .next_pulse(next_pulse),
        .pause_tgl(pause_tgl),
        .segs(segs),
        .page_idx(page_idx),
        .paused(paused)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7*ND-1:0] segs;
        logic [1:0]      page;
        logic            paused;
        logic            ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    localparam logic [DATA_W-1:0] BLK_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [DATA_W-1:0] BLK_B = 128'h0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    localparam logic [DATA_W-1:0] BLK_C = 128'hDEADBEEFCAFEF00D_0123456789ABCDEF;
    localparam logic [DATA_W-1:0] BLK_D = 128'h13579BDF02468ACE_FDB97531ECA86420;

    function automatic logic [7*ND-1:0] model_segs(input logic [DATA_W-1:0] blk, input int page,
                                                   input bit blank);
        logic [7*ND-1:0] r;
        logic [3:0]      nib;
        r = '1;
        if (!blank) begin
            for (int k = 0; k < int'(ND); k++) begin
                nib = blk[(page*int'(ND) + k)*4 +: 4];
                r[7*k +: 7] = dec_tab[nib];
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_blank();
        exp_q.push_back('{segs: '1, page: 2'd0, paused: 1'b0, ready: 1'b1});
    endtask

    task automatic push_show(input logic [DATA_W-1:0] blk, input int page, input bit blank,
                             input bit pz);
        exp_q.push_back('{segs: model_segs(blk, page, blank), page: 2'(page), paused: pz,
                          ready: !pz});
    endtask

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, ".segs"}, 64'(segs), 64'(e.segs));
            cmp({tag, ".page_idx"}, 64'(page_idx), 64'(e.page));
            cmp({tag, ".paused"}, 64'(paused), 64'(e.paused));
            cmp({tag, ".in_ready"}, 64'(in_ready), 64'(e.ready));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        push_blank();
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Capture block A: page 0 appears on the next cycle.
        in_valid = 1'b1;
        in_data  = BLK_A;
        push_show(BLK_A, 0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("cap_a");
        for (int c = 1; c < 4; c++) begin
            push_show(BLK_A, 0, BLINK && (c % 2 == 1), 1'b0);
            tick();
            check("a_page0_dwell");
        end

        // Auto-advance every 4 clocks, wrapping 3 -> 0.
        push_show(BLK_A, 1, 1'b0, 1'b0);
        tick();
        check("auto_page1");
        for (int p = 2; p < 5; p++) begin
            repeat (3) tick();
            push_show(BLK_A, p % 4, 1'b0, 1'b0);
            tick();
            check("auto_page");
        end

        // Pause freezes display and blocks capture; next_pulse still advances.
        pause_tgl = 1'b1;
        push_show(BLK_A, 0, 1'b0, 1'b1);
        tick();
        pause_tgl = 1'b0;
        check("pause_on");
        in_valid = 1'b1;
        in_data  = BLK_B;
        push_show(BLK_A, 0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("pause_no_capture");
        next_pulse = 1'b1;
        push_show(BLK_A, 1, 1'b0, 1'b1);
        tick();
        next_pulse = 1'b0;
        check("pause_next");
        repeat (5) tick();
        push_show(BLK_A, 1, 1'b0, 1'b1);
        tick();
        check("pause_hold");
        pause_tgl = 1'b1;
        push_show(BLK_A, 1, 1'b0, 1'b0);
        tick();
        pause_tgl = 1'b0;
        check("resume");
        repeat (3) tick();
        push_show(BLK_A, 2, 1'b0, 1'b0);
        tick();
        check("resume_dwell");

        // Page 2 at dwell 3: capture with next_pulse lands on page 0, counter cleared.
        repeat (3) tick();
        in_valid   = 1'b1;
        in_data    = BLK_B;
        next_pulse = 1'b1;
        push_show(BLK_B, 0, 1'b0, 1'b0);
        tick();
        in_valid   = 1'b0;
        next_pulse = 1'b0;
        check("cap_beats_next");
        for (int c = 1; c < 4; c++) begin
            push_show(BLK_B, 0, BLINK && (c % 2 == 1), 1'b0);
            tick();
            check("b_page0_dwell");
        end
        push_show(BLK_B, 1, 1'b0, 1'b0);
        tick();
        check("b_page1");

        // Asynchronous reset mid-page, away from any clock edge.
        tick();
        #2 rst_n = 1'b0;
        #1;
        push_blank();
        check("async_reset");
        @(negedge clk);
        rst_n      = 1'b1;
        next_pulse = 1'b1;
        push_blank();
        tick();
        next_pulse = 1'b0;
        check("idle_next_ignored");
        pause_tgl = 1'b1;
        push_blank();
        tick();
        pause_tgl = 1'b0;
        check("idle_pause_ignored");

        // Capture, then capture together with pause_tgl: new block shown and paused.
        in_valid = 1'b1;
        in_data  = BLK_C;
        push_show(BLK_C, 0, 1'b0, 1'b0);
        tick();
        check("cap_c");
        in_data   = BLK_D;
        pause_tgl = 1'b1;
        push_show(BLK_D, 0, 1'b0, 1'b1);
        tick();
        in_valid  = 1'b0;
        pause_tgl = 1'b0;
        check("cap_and_pause");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
